// File: rtl/kuz_apb_pkg.sv
// Shared definitions for the Kuznechik APB streamer: wrapper register map,
// control words, FSM state encodings and small address/data helpers.
package kuz_apb_pkg;

    // Wrapper register offsets relative to the wrapper base address
    localparam logic [31:0] CTRL_OFF = 32'h0000_0000;
    localparam logic [31:0] DIN_OFF  = 32'h0000_0004;
    localparam logic [31:0] DOUT_OFF = 32'h0000_0014;

    // Control register values: run + request, and run with request cleared
    localparam logic [31:0] CTRL_START = 32'h0000_0101;
    localparam logic [31:0] CTRL_CLR   = 32'h0000_0001;

    // Bit of the control register that reports a finished result
    localparam int VALID_BIT = 16;

    // Byte strobes: full word for data, low two bytes for control
    localparam logic [3:0] STRB_WORD = 4'hF;
    localparam logic [3:0] STRB_CTRL = 4'h3;

    // Block-level sequencing states
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_DATA,
        ST_START,
        ST_POLL,
        ST_RD_DATA,
        ST_CLR,
        ST_OUT
    } state_t;

    // Phases of a single APB transfer
    typedef enum logic [1:0] {
        PH_IDLE,
        PH_SETUP,
        PH_ACCESS
    } apb_phase_t;

    // Offset of 32-bit word idx within a four-word register bank
    function automatic logic [31:0] word_off(input logic [31:0] bank_off, input logic [1:0] idx);
        return bank_off + {28'h0, idx, 2'b00};
    endfunction

    // Word idx of a 128-bit block, word 0 being bits [31:0]
    function automatic logic [31:0] block_word(input logic [127:0] blk, input logic [1:0] idx);
        return blk[idx*32 +: 32];
    endfunction

endpackage

// File: rtl/kuz_apb_master_if.sv
// Single-transfer APB master engine. A request is accepted when the engine
// is idle or in the same cycle the current transfer completes, which lets
// the sequencer chain transfers ACCESS -> SETUP with no idle cycle.
// Address/control/data are registered at acceptance and held until done.
module kuz_apb_master_if
    import kuz_apb_pkg::*;
(
    input  logic        pclk_i,
    input  logic        presetn_i,
    // request side
    input  logic        req,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  strb,
    input  logic        write,
    // response side
    output logic        done,
    output logic [31:0] rdata,
    output logic        err,
    // APB master port
    output logic [31:0] paddr_o,
    output logic        psel_o,
    output logic        penable_o,
    output logic        pwrite_o,
    output logic [31:0] pwdata_o,
    output logic [3:0]  pstrb_o,
    input  logic [31:0] prdata_i,
    input  logic        pready_i,
    input  logic        pslverr_i
);

    apb_phase_t phase_reg;
    apb_phase_t phase_next;
    logic       accept;

    assign done      = (phase_reg == PH_ACCESS) && pready_i;
    assign rdata     = prdata_i;
    assign err       = pslverr_i;
    assign accept    = req && ((phase_reg == PH_IDLE) || done);
    assign psel_o    = (phase_reg != PH_IDLE);
    assign penable_o = (phase_reg == PH_ACCESS);

    // Phase sequencing: accept -> SETUP -> ACCESS (wait for pready) -> idle or next SETUP
    always_comb begin
        phase_next = phase_reg;
        if (accept) begin
            phase_next = PH_SETUP;
        end else if (phase_reg == PH_SETUP) begin
            phase_next = PH_ACCESS;
        end else if (done) begin
            phase_next = PH_IDLE;
        end
    end

    // Phase register and request capture; reset drops psel/penable at once
    always_ff @(posedge pclk_i or negedge presetn_i) begin
        if (!presetn_i) begin
            phase_reg <= PH_IDLE;
            paddr_o   <= 32'h0;
            pwdata_o  <= 32'h0;
            pstrb_o   <= 4'h0;
            pwrite_o  <= 1'b0;
        end else begin
            phase_reg <= phase_next;
            if (accept) begin
                paddr_o  <= addr;
                pwdata_o <= wdata;
                pstrb_o  <= strb;
                pwrite_o <= write;
            end
        end
    end

endmodule

// File: rtl/kuz_apb_streamer.sv
// Kuznechik APB streamer: turns a 128-bit valid/ready block stream into the
// wrapper register sequence (load data, start, poll, read result, clear) and
// presents the result on a 128-bit output stream.
// Optional feature macro: KUZ_STREAMER_TIMEOUT_EN bounds the number of status
// polls per block to POLL_MAX, after which the block is aborted.
module kuz_apb_streamer
    import kuz_apb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          POLL_MAX  = 1024
) (
    input  logic         pclk_i,
    input  logic         presetn_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [127:0] in_data_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [127:0] out_data_o,
    output logic         err_o,
    output logic [31:0]  paddr_o,
    output logic         psel_o,
    output logic         penable_o,
    output logic         pwrite_o,
    output logic [31:0]  pwdata_o,
    output logic [3:0]   pstrb_o,
    input  logic [31:0]  prdata_i,
    input  logic         pready_i,
    input  logic         pslverr_i
);

    state_t         state_reg, state_next;
    logic [1:0]     idx_reg, idx_next;
    logic           abort_reg, abort_next;
    logic           err_reg, err_next;
    logic [127:0]   data_reg;
    logic [127:0]   result_reg;
    logic           start_block;
    logic           capture;
    logic           poll_last;

    logic           req;
    logic [31:0]    req_addr;
    logic [31:0]    req_wdata;
    logic [3:0]     req_strb;
    logic           req_write;
    logic           done;
    logic [31:0]    rdata;
    logic           xfer_err;

    assign in_ready_o  = (state_reg == ST_IDLE);
    assign out_valid_o = (state_reg == ST_OUT);
    assign out_data_o  = result_reg;
    assign err_o       = err_reg;

`ifdef KUZ_STREAMER_TIMEOUT_EN
    localparam int POLL_W = (POLL_MAX > 1) ? $clog2(POLL_MAX) : 1;
    logic [POLL_W-1:0] poll_cnt_reg;

    // The last permitted status read is the one where the count reaches POLL_MAX-1
    assign poll_last = (poll_cnt_reg == POLL_W'(POLL_MAX - 1));

    // Count completed status reads of the current block
    always_ff @(posedge pclk_i or negedge presetn_i) begin
        if (!presetn_i) begin
            poll_cnt_reg <= '0;
        end else if (state_reg != ST_POLL) begin
            poll_cnt_reg <= '0;
        end else if (done && !poll_last) begin
            poll_cnt_reg <= poll_cnt_reg + 1'b1;
        end
    end
`else
    assign poll_last = 1'b0;
`endif

    // Block sequencing: next state, word index, abort tracking and error pulse
    always_comb begin
        state_next  = state_reg;
        idx_next    = idx_reg;
        abort_next  = abort_reg;
        err_next    = 1'b0;
        start_block = 1'b0;
        capture     = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (in_valid_i) begin
                    start_block = 1'b1;
                    state_next  = ST_WR_DATA;
                    idx_next    = 2'd0;
                    abort_next  = 1'b0;
                end
            end
            ST_WR_DATA: begin
                if (done) begin
                    if (xfer_err) begin
                        abort_next = 1'b1;
                        err_next   = 1'b1;
                        state_next = ST_CLR;
                    end else if (idx_reg == 2'd3) begin
                        state_next = ST_START;
                        idx_next   = 2'd0;
                    end else begin
                        idx_next = idx_reg + 2'd1;
                    end
                end
            end
            ST_START: begin
                if (done) begin
                    if (xfer_err) begin
                        abort_next = 1'b1;
                        err_next   = 1'b1;
                        state_next = ST_CLR;
                    end else begin
                        state_next = ST_POLL;
                    end
                end
            end
            ST_POLL: begin
                if (done) begin
                    if (xfer_err || (!rdata[VALID_BIT] && poll_last)) begin
                        abort_next = 1'b1;
                        err_next   = 1'b1;
                        state_next = ST_CLR;
                    end else if (rdata[VALID_BIT]) begin
                        state_next = ST_RD_DATA;
                        idx_next   = 2'd0;
                    end
                end
            end
            ST_RD_DATA: begin
                if (done) begin
                    if (xfer_err) begin
                        abort_next = 1'b1;
                        err_next   = 1'b1;
                        state_next = ST_CLR;
                    end else begin
                        capture = 1'b1;
                        if (idx_reg == 2'd3) begin
                            state_next = ST_CLR;
                            idx_next   = 2'd0;
                        end else begin
                            idx_next = idx_reg + 2'd1;
                        end
                    end
                end
            end
            ST_CLR: begin
                // An error on the clear write is deliberately ignored
                if (done) begin
                    state_next = abort_reg ? ST_IDLE : ST_OUT;
                end
            end
            ST_OUT: begin
                if (out_ready_i) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Next transfer is built from the upcoming state so it issues in the completion cycle
    always_comb begin
        req_addr  = 32'h0;
        req_wdata = 32'h0;
        req_strb  = 4'h0;
        req_write = 1'b0;
        case (state_next)
            ST_WR_DATA: begin
                req_addr  = BASE_ADDR + word_off(DIN_OFF, idx_next);
                // On the accept cycle the block is not latched yet, so take it from the input
                req_wdata = (state_reg == ST_IDLE) ? in_data_i[31:0]
                                                   : block_word(data_reg, idx_next);
                req_strb  = STRB_WORD;
                req_write = 1'b1;
            end
            ST_START: begin
                req_addr  = BASE_ADDR + CTRL_OFF;
                req_wdata = CTRL_START;
                req_strb  = STRB_CTRL;
                req_write = 1'b1;
            end
            ST_POLL: begin
                req_addr = BASE_ADDR + CTRL_OFF;
            end
            ST_RD_DATA: begin
                req_addr = BASE_ADDR + word_off(DOUT_OFF, idx_next);
            end
            ST_CLR: begin
                req_addr  = BASE_ADDR + CTRL_OFF;
                req_wdata = CTRL_CLR;
                req_strb  = STRB_CTRL;
                req_write = 1'b1;
            end
            default: begin
                req_addr = 32'h0;
            end
        endcase
        req = start_block ||
              (done && (state_next inside {ST_WR_DATA, ST_START, ST_POLL, ST_RD_DATA, ST_CLR}));
    end

    // State, block and result registers
    always_ff @(posedge pclk_i or negedge presetn_i) begin
        if (!presetn_i) begin
            state_reg  <= ST_IDLE;
            idx_reg    <= 2'd0;
            abort_reg  <= 1'b0;
            err_reg    <= 1'b0;
            data_reg   <= 128'h0;
            result_reg <= 128'h0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            abort_reg <= abort_next;
            err_reg   <= err_next;
            if (start_block) begin
                data_reg <= in_data_i;
            end
            if (capture) begin
                result_reg[idx_reg*32 +: 32] <= rdata;
            end
        end
    end

    kuz_apb_master_if u_master (
        .pclk_i    (pclk_i),
        .presetn_i (presetn_i),
        .req       (req),
        .addr      (req_addr),
        .wdata     (req_wdata),
        .strb      (req_strb),
        .write     (req_write),
        .done      (done),
        .rdata     (rdata),
        .err       (xfer_err),
        .paddr_o   (paddr_o),
        .psel_o    (psel_o),
        .penable_o (penable_o),
        .pwrite_o  (pwrite_o),
        .pwdata_o  (pwdata_o),
        .pstrb_o   (pstrb_o),
        .prdata_i  (prdata_i),
        .pready_i  (pready_i),
        .pslverr_i (pslverr_i)
    );

endmodule

// File: tb/tb_kuz_apb_streamer.sv
// Scoreboard bench for kuz_apb_streamer: stimulus pushes the expected APB
// trace and output blocks; monitors pop and compare as the DUT presents them.
module tb_kuz_apb_streamer;

    localparam logic [31:0] BASE = 32'h4000_1000;

    logic         clk = 1'b0;
    logic         presetn = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] in_data = 128'h0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [127:0] out_data;
    logic         err;
    logic [31:0]  paddr;
    logic         psel, penable, pwrite;
    logic [31:0]  pwdata;
    logic [3:0]   pstrb;
    logic [31:0]  prdata;
    logic         pready, pslverr;

    always #5 clk = ~clk;

    kuz_apb_streamer #(.BASE_ADDR(BASE), .POLL_MAX(4)) dut (
        .pclk_i(clk), .presetn_i(presetn),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
        .err_o(err),
        .paddr_o(paddr), .psel_o(psel), .penable_o(penable), .pwrite_o(pwrite),
        .pwdata_o(pwdata), .pstrb_o(pstrb), .prdata_i(prdata),
        .pready_i(pready), .pslverr_i(pslverr)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- wrapper model ----------------
    int           wait_states = 0;
    int           acc_cnt     = 0;
    int           polls_hold  = 0;
    int           poll_base   = 0;
    int           ctrl_reads  = 0;
    bit           never_valid = 1'b0;
    bit           inject_err  = 1'b0;
    logic [127:0] model_result = 128'h0;
    logic         model_valid;

    assign pready  = (acc_cnt >= wait_states);
    assign pslverr = inject_err && pwrite && (paddr == BASE + 32'h8);
    assign model_valid = !never_valid && ((ctrl_reads - poll_base) >= polls_hold);

    always_comb begin
        prdata = 32'h0;
        case (paddr - BASE)
            32'h00: prdata = {8'h00, 7'h00, model_valid, 8'h01, 8'h01};
            32'h14: prdata = model_result[31:0];
            32'h18: prdata = model_result[63:32];
            32'h1C: prdata = model_result[95:64];
            32'h20: prdata = model_result[127:96];
            default: prdata = 32'h0;
        endcase
    end

    always @(posedge clk) begin
        if (psel && penable && !pready) acc_cnt <= acc_cnt + 1;
        else acc_cnt <= 0;
        if (presetn && psel && penable && pready && !pwrite && paddr == BASE)
            ctrl_reads <= ctrl_reads + 1;
    end

    // ---------------- scoreboards ----------------
    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  strb;
    } apb_t;

    apb_t         apb_q[$];
    logic [127:0] out_q[$];
    int           out_cnt = 0;
    int           err_cnt = 0;

    task automatic exp_wr(input logic [31:0] off, input logic [31:0] d, input logic [3:0] s);
        apb_q.push_back('{addr: BASE + off, write: 1'b1, wdata: d, strb: s});
    endtask

    task automatic exp_rd(input logic [31:0] off);
        apb_q.push_back('{addr: BASE + off, write: 1'b0, wdata: 32'h0, strb: 4'h0});
    endtask

    task automatic exp_head(input logic [127:0] pt, input int polls);
        for (int i = 0; i < 4; i++) exp_wr(32'h04 + 4 * i, pt[i*32 +: 32], 4'hF);
        exp_wr(32'h00, 32'h0000_0101, 4'h3);
        for (int i = 0; i < polls; i++) exp_rd(32'h00);
    endtask

    task automatic exp_full(input logic [127:0] pt, input int polls, input logic [127:0] res);
        exp_head(pt, polls);
        for (int i = 0; i < 4; i++) exp_rd(32'h14 + 4 * i);
        exp_wr(32'h00, 32'h0000_0001, 4'h3);
        out_q.push_back(res);
    endtask

    // APB trace monitor: compare every completing transfer
    apb_t a_exp;
    always @(negedge clk) begin
        if (presetn && psel && penable && pready) begin
            if (apb_q.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL apb_unexpected: got addr %0h write %0b, expected no transfer", paddr, pwrite);
            end else begin
                a_exp = apb_q.pop_front();
                check("apb_addr", paddr, a_exp.addr);
                check("apb_write", pwrite, a_exp.write);
                if (a_exp.write) begin
                    check("apb_wdata", pwdata, a_exp.wdata);
                    check("apb_strb", pstrb, a_exp.strb);
                end
            end
        end
    end

    // Protocol monitor: fields captured at SETUP must hold throughout ACCESS
    logic [68:0] setup_cap;
    always @(negedge clk) begin
        if (psel && !penable) setup_cap <= {paddr, pwrite, pwdata, pstrb};
        if (psel && penable) check("apb_stable", {paddr, pwrite, pwdata, pstrb}, setup_cap);
    end

    // Output monitor
    logic [127:0] o_exp;
    always @(negedge clk) begin
        if (presetn && out_valid && out_ready) begin
            out_cnt++;
            if (out_q.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL out_unexpected: got %0h, expected no output", out_data);
            end else begin
                o_exp = out_q.pop_front();
                check("out_data", out_data, o_exp);
            end
        end
        if (presetn && err) err_cnt++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic [127:0] pt);
        int cyc;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = pt;
        cyc = 0;
        while (!in_ready && cyc < 200) begin @(negedge clk); cyc++; end
        check("accept_ready", in_ready, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = ~pt;
        check("busy_in_ready", in_ready, 1'b0);
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 2000) begin @(posedge clk); #1; lat++; end
        check("out_valid_seen", out_valid, 1'b1);
    endtask

    task automatic wait_idle();
        int cyc;
        cyc = 0;
        while (!in_ready && cyc < 2000) begin @(posedge clk); #1; cyc++; end
        check("back_to_idle", in_ready, 1'b1);
    endtask

    localparam logic [127:0] PT1 = 128'h1122334455667700ffeeddccbbaa9988;
    localparam logic [127:0] CT1 = 128'h7f679d90bebc24305a468d42b9d4edcd;
    localparam logic [127:0] PT2 = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [127:0] CT2 = 128'hdeadbeef0badf00dcafef00d12345678;
    localparam logic [127:0] PT3 = 128'ha5a5a5a55a5a5a5a0f0f0f0ff0f0f0f0;
    localparam logic [127:0] CT3 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] PT4 = 128'hcccccccc333333339999999966666666;
    localparam logic [127:0] CT4 = 128'h13579bdf2468ace0fedcba9801234567;

    initial begin
        int lat;
        int e0, o0, n;

        // Reset values while reset is held
        repeat (2) @(negedge clk);
        check("rst_psel", psel, 1'b0);
        check("rst_penable", penable, 1'b0);
        check("rst_pwrite", pwrite, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_addr_data_strb", {paddr, pwdata, pstrb}, 68'h0);
        check("rst_out_data", out_data, 128'h0);
        presetn = 1'b1;

        // Basic block, pready tied high: trace, result and minimum latency
        model_result = CT1; polls_hold = 0; poll_base = ctrl_reads;
        exp_full(PT1, 1, CT1);
        send(PT1);
        wait_out(lat);
        check("latency_min", lat, 22);
        wait_idle();
        check("basic_apb_drained", apb_q.size(), 0);

        // Five not-ready polls then completion, with one wait state per transfer
        wait_states = 1; model_result = CT2; polls_hold = 5; poll_base = ctrl_reads;
        exp_full(PT2, 6, CT2);
        send(PT2);
        wait_out(lat);
        wait_idle();
        check("poll_reads", ctrl_reads - poll_base, 6);
        check("poll_apb_drained", apb_q.size(), 0);
        wait_states = 0;

        // Slave error on the second data write: abort, clear, no output
        e0 = err_cnt; o0 = out_cnt; inject_err = 1'b1; polls_hold = 0; poll_base = ctrl_reads;
        exp_wr(32'h04, PT3[31:0], 4'hF);
        exp_wr(32'h08, PT3[63:32], 4'hF);
        exp_wr(32'h00, 32'h0000_0001, 4'h3);
        send(PT3);
        wait_idle();
        repeat (3) @(negedge clk);
        inject_err = 1'b0;
        check("slverr_err_pulses", err_cnt - e0, 1);
        check("slverr_no_output", out_cnt - o0, 0);
        check("slverr_apb_drained", apb_q.size(), 0);

        // Output backpressure: hold, no APB, second block refused until handshake
        out_ready = 1'b0; model_result = CT3; poll_base = ctrl_reads;
        exp_full(PT3, 1, CT3);
        send(PT3);
        wait_out(lat);
        @(negedge clk);
        in_valid = 1'b1; in_data = PT4;
        exp_full(PT4, 1, CT4);
        for (int i = 0; i < 10; i++) begin
            check("bp_out_valid", out_valid, 1'b1);
            check("bp_out_data", out_data, CT3);
            check("bp_no_apb", psel, 1'b0);
            check("bp_in_ready", in_ready, 1'b0);
            @(negedge clk);
        end
        model_result = CT4; poll_base = ctrl_reads;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_ready_after_hs", in_ready, 1'b1);
        @(posedge clk); #1;
        check("bp_second_accepted", in_ready, 1'b0);
        in_valid = 1'b0;
        wait_out(lat);
        wait_idle();
        check("bp_apb_drained", apb_q.size(), 0);

        // Reset during the third poll ACCESS cycle
        polls_hold = 100000; poll_base = ctrl_reads;
        exp_head(PT2, 3);
        send(PT2);
        n = 0;
        for (int cyc = 0; cyc < 300 && n < 3; cyc++) begin
            @(negedge clk);
            if (psel && penable && !pwrite && paddr == BASE) n++;
        end
        check("rst_poll_reached", n, 3);
        #1 presetn = 1'b0;
        #1;
        check("async_psel", psel, 1'b0);
        check("async_penable", penable, 1'b0);
        check("async_in_ready", in_ready, 1'b1);
        repeat (2) @(negedge clk);
        presetn = 1'b1;
        check("rst_apb_drained", apb_q.size(), 0);

        // Normal block after reset release
        polls_hold = 0; poll_base = ctrl_reads; model_result = CT1;
        exp_full(PT1, 1, CT1);
        send(PT1);
        wait_out(lat);
        check("post_rst_latency", lat, 22);
        wait_idle();
        check("post_rst_apb_drained", apb_q.size(), 0);

`ifdef KUZ_STREAMER_TIMEOUT_EN
        // Poll timeout with POLL_MAX = 4
        e0 = err_cnt; o0 = out_cnt; never_valid = 1'b1; poll_base = ctrl_reads;
        exp_head(PT4, 4);
        exp_wr(32'h00, 32'h0000_0001, 4'h3);
        send(PT4);
        wait_idle();
        repeat (3) @(negedge clk);
        never_valid = 1'b0;
        check("timeout_reads", ctrl_reads - poll_base, 4);
        check("timeout_err_pulses", err_cnt - e0, 1);
        check("timeout_no_output", out_cnt - o0, 0);
        check("timeout_apb_drained", apb_q.size(), 0);
`endif

        repeat (3) @(negedge clk);
        check("out_q_drained", out_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/kuz_apb_streamer.md
# kuz_apb_streamer

APB master sequencer that sits directly upstream of the Kuznechik APB cipher wrapper and converts a 128-bit valid/ready block stream into APB register transactions. For each input block it loads the plaintext, starts the core, polls for completion, and reads back the result. It presents the result on a 128-bit output stream. It lets a streaming datapath use the cipher without a CPU.

## Interface
- BASE_ADDR, 32'h0000_0000: APB base address of the cipher wrapper.
- POLL_MAX, 1024: maximum status reads per block before timeout. Used only with the timeout feature.
- pclk_i  in  1  clock.
- presetn_i  in  1  reset, asynchronous, active-low.
- in_valid_i / in_ready_o  in/out  1  input block handshake.
- in_data_i  in  128  plaintext block.
- out_valid_o / out_ready_i  out/in  1  result handshake.
- out_data_o  out  128  ciphertext block.
- err_o  out  1  one-cycle pulse on block abort.
- paddr_o  out  32  APB address.
- psel_o, penable_o, pwrite_o  out  1  APB control.
- pwdata_o  out  32  APB write data.
- pstrb_o  out  4  APB byte strobes.
- prdata_i  in  32  APB read data.
- pready_i, pslverr_i  in  1  APB completion and error.

## Operation
Wrapper register map (offsets from BASE_ADDR):
- 0x00: byte0 = core run (1 = out of reset), byte1 = request/ack, byte2 = valid (RO), byte3 = busy (RO).
- 0x04–0x10: data_in words; 0x04 = bits [31:0] … 0x10 = [127:96].
- 0x14–0x20: data_out words, same ordering.

State machine:
- IDLE: in_ready_o = 1. When in_valid_i is high, latch in_data_i and go to WR_DATA.
- WR_DATA: four writes, word index 0..3, to 0x04 + 4·idx. pstrb = 4'hF.
- START: write 0x0000_0101 to 0x00 with pstrb 4'h3.
- POLL: read 0x00. If prdata_i[16] is set, go to RD_DATA; otherwise repeat the read.
- RD_DATA: four reads from 0x14 + 4·idx, each captured into the result register.
- CLR: write 0x0000_0001 to 0x00 with pstrb 4'h3.
- OUT: hold out_valid_o high until out_ready_i is high, then return to IDLE.
- If pslverr_i is high on any completing transfer: pulse err_o, drop the block, perform the CLR write (its error is ignored), then return to IDLE. No output is produced.
- Only one block is in flight. in_ready_o is low in every state except IDLE.

## Timing
- APB transfer: SETUP cycle (psel_o = 1, penable_o = 0), then ACCESS (psel_o = 1, penable_o = 1) until pready_i is high.
- Back-to-back transfers go straight from ACCESS to the next SETUP, with no idle cycle.
- paddr_o, pwrite_o, pwdata_o and pstrb_o are stable from SETUP through completion.
- Minimum block latency, input accept to out_valid_o: 11 transfers (4 + 1 + 1 poll + 4 + 1) × 2 cycles = 22 cycles, with pready_i tied high.
- Reset values: psel_o, penable_o, pwrite_o, out_valid_o, err_o = 0; in_ready_o = 1; paddr_o, pwdata_o, pstrb_o, out_data_o = 0.
- Reset asserted mid-transfer drops psel_o and penable_o immediately. The FSM returns to IDLE and the latched data is discarded.
- If out_ready_i is already high when out_valid_o rises, the handshake completes in that cycle. in_ready_o rises on the next cycle.
- in_data_i is sampled only on the cycle where in_valid_i and in_ready_o are both high. Later changes to in_data_i have no effect on the block in flight.

## Configuration
- KUZ_STREAMER_TIMEOUT_EN defined: a poll counter counts POLL reads. If the POLL_MAX-th read still shows valid = 0, take the error path: err_o pulse, then CLR.
- Not defined: no counter logic; POLL repeats indefinitely. The POLL_MAX parameter is present but unused.

## Structure
- Package kuz_apb_pkg holds:
  - register offsets: CTRL 0x00, DIN 0x04, DOUT 0x14;
  - control constants CTRL_START = 32'h0101 and CTRL_CLR = 32'h0001;
  - the valid bit index, 16;
  - the state enum.
- Sub-module kuz_apb_master_if is a single-transfer APB engine.
  - Request side: addr, wdata, strb, write, req.
  - Response side: done, rdata, err.
  - The top-level FSM drives one request at a time.

## Test plan
- Plaintext 128'h1122334455667700ffeeddccbbaa9988, wrapper model returning 128'h7f679d90bebc24305a468d42b9d4edcd:
  - out_data_o equals that value;
  - APB trace is four DIN writes, START, poll(s), four DOUT reads, CLR.
- Model holds valid = 0 for 5 polls → exactly 6 reads of 0x00, then normal completion.
- pslverr_i on the second DIN write → err_o pulses once, CLR is issued, no out_valid_o, in_ready_o returns high.
- out_ready_i held low 10 cycles → out_valid_o and out_data_o stable for all 10 cycles; no APB activity; second in_valid_i is not accepted.
- presetn_i low during a POLL ACCESS cycle → psel_o = 0 and penable_o = 0 asynchronously; after release the next block runs normally.
- With KUZ_STREAMER_TIMEOUT_EN and POLL_MAX = 4, model never sets valid → 4 reads, err_o pulse, CLR.
